// File: rtl/rom_scan_controller.sv
// Sequencer that walks rom_reader across a (possibly wrapping) address range with
// step pulses, verifies each address, settles, then offers every word on valid/ready.
module rom_scan_controller #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int ADDR_TIMEOUT  = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] first_address,
  input  logic [ADDRESS_WIDTH-1:0] last_address,
  input  logic [ADDRESS_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic                     increment_address,
  output logic                     decrement_address,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);
  localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(ADDR_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(ADDR_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX     = TMO_W'(ADDR_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, SEEK_PULSE, SEEK_WAIT, SETTLE, PRESENT, STEP_PULSE, STEP_WAIT, DONE, ERROR
  } state_t;

  state_t                   state, state_d;
  logic [ADDRESS_WIDTH-1:0] first_q, first_d, last_q, last_d, target_q, target_d;
  logic                     dir_up_q, dir_up_d, pending_q, pending_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0]    data_d;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic                     error_d, busy_d, inc_d, dec_d, valid_d, done_d;

  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (v == TMO_MAX) ? v : v + TMO_W'(1);
  endfunction

  always_comb begin
    state_d   = state;
    first_d   = first_q;
    last_d    = last_q;
    target_d  = target_q;
    dir_up_d  = dir_up_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    data_d    = out_data;
    addr_d    = out_address;
    error_d   = error;
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          first_d   = first_address;
          last_d    = last_address;
          error_d   = 1'b0;
          pending_d = 1'b0;
          state_d   = SEEK_WAIT;
        end
      end
      SEEK_WAIT: begin
        // A pending seek step must land on its target before the range check resumes.
        if (pending_q && rom_address != target_q) begin
          if (tmo_q == TMO_LAST) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else begin
            tmo_d = sat_inc(tmo_q);
          end
        end else if (rom_address == first_q) begin
          pending_d = 1'b0;
          cnt_d     = '0;
          state_d   = SETTLE;
        end else begin
          dir_up_d = rom_address < first_q;
          target_d = (rom_address < first_q) ? rom_address + ADDRESS_WIDTH'(1)
                                              : rom_address - ADDRESS_WIDTH'(1);
          cnt_d    = '0;
          state_d  = SEEK_PULSE;
        end
      end
      SEEK_PULSE, STEP_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          tmo_d     = '0;
          pending_d = 1'b1;
          state_d   = (state == SEEK_PULSE) ? SEEK_WAIT : STEP_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STEP_WAIT: begin
        if (rom_address == target_q) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else begin
          tmo_d = sat_inc(tmo_q);
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          data_d  = rom_data;
          addr_d  = rom_address;
          state_d = PRESENT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (out_address == last_q) begin
            state_d = DONE;
          end else begin
            target_d = out_address + ADDRESS_WIDTH'(1);
            dir_up_d = 1'b1;
            cnt_d    = '0;
            state_d  = STEP_PULSE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      error_d = error;
    end
    busy_d  = !(state_d inside {IDLE, DONE, ERROR});
    inc_d   = (state_d == SEEK_PULSE || state_d == STEP_PULSE) && dir_up_d;
    dec_d   = (state_d == SEEK_PULSE) && !dir_up_d;
    valid_d = (state_d == PRESENT);
    done_d  = (state_d == DONE) && (state != DONE);
  end

  // Register stage: every output comes straight from a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      first_q           <= '0;
      last_q            <= '0;
      target_q          <= '0;
      dir_up_q          <= 1'b0;
      pending_q         <= 1'b0;
      cnt_q             <= '0;
      tmo_q             <= '0;
      out_data          <= '0;
      out_address       <= '0;
      error             <= 1'b0;
      busy              <= 1'b0;
      increment_address <= 1'b0;
      decrement_address <= 1'b0;
      out_valid         <= 1'b0;
      done              <= 1'b0;
    end else begin
      state             <= state_d;
      first_q           <= first_d;
      last_q            <= last_d;
      target_q          <= target_d;
      dir_up_q          <= dir_up_d;
      pending_q         <= pending_d;
      cnt_q             <= cnt_d;
      tmo_q             <= tmo_d;
      out_data          <= data_d;
      out_address       <= addr_d;
      error             <= error_d;
      busy              <= busy_d;
      increment_address <= inc_d;
      decrement_address <= dec_d;
      out_valid         <= valid_d;
      done              <= done_d;
    end
  end

endmodule

// File: tb/tb_rom_scan_controller.sv
// Directed + randomized bench for rom_scan_controller with a behavioural rom_reader
// model and a range-arithmetic reference for the expected word stream.
module tb_rom_scan_controller;
  localparam int DW = 8;
  localparam int AW = 9;
  localparam int PC = 4;
  localparam int SC = 16;
  localparam int TO = 64;
  localparam int NA = 512;

  logic          clk = 1'b0;
  logic          reset_n, start, abort, out_ready;
  logic [AW-1:0] first_address, last_address, rom_address, out_address;
  logic [DW-1:0] rom_data, out_data;
  logic          increment_address, decrement_address, out_valid, busy, done, error;

  always #5 clk = ~clk;

  rom_scan_controller #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .PULSE_CYCLES(PC),
    .SETTLE_CYCLES(SC), .ADDR_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .first_address(first_address), .last_address(last_address),
    .rom_address(rom_address), .rom_data(rom_data),
    .increment_address(increment_address), .decrement_address(decrement_address),
    .out_data(out_data), .out_address(out_address), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .error(error)
  );

  logic [DW-1:0] mem [0:NA-1];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int inc_pulses, dec_pulses, pulse_len, bad_len, both_cnt, done_cnt;
  int pulse_end_cyc, err_cyc, ignore_inc;
  int stall_idx, stall_left, unstable, inc_in_stall;
  bit stall_started, inc_prev, dec_prev, err_prev;
  logic [DW-1:0] hold_data;
  logic [AW-1:0] hold_addr;
  logic [AW-1:0] got_addr [$];
  logic [DW-1:0] got_data [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of the reader model, downstream sink and event log, sampled at negedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (increment_address && decrement_address) both_cnt++;
    if (increment_address && !inc_prev) begin
      inc_pulses++;
      if (inc_pulses != ignore_inc) rom_address = rom_address + 9'd1;
    end
    if (decrement_address && !dec_prev) begin
      dec_pulses++;
      rom_address = rom_address - 9'd1;
    end
    if (increment_address || decrement_address) pulse_len++;
    else if (inc_prev || dec_prev) begin
      if (pulse_len != PC) bad_len++;
      pulse_len = 0;
      pulse_end_cyc = cyc;
    end
    inc_prev = increment_address;
    dec_prev = decrement_address;
    if (stall_idx >= 0 && !stall_started && out_valid && got_addr.size() == stall_idx) begin
      stall_started = 1'b1;
      stall_left = 20;
      hold_data = out_data;
      hold_addr = out_address;
    end
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
      if (!out_valid || out_data !== hold_data || out_address !== hold_addr) unstable++;
      if (increment_address) inc_in_stall++;
    end else begin
      out_ready = 1'b1;
    end
    if (out_valid && out_ready) begin
      got_addr.push_back(out_address);
      got_data.push_back(out_data);
    end
    if (done) done_cnt++;
    if (error && !err_prev) err_cyc = cyc;
    err_prev = error;
    rom_data = mem[rom_address];
  endtask

  task automatic clear_log();
    got_addr.delete();
    got_data.delete();
    inc_pulses = 0; dec_pulses = 0; pulse_len = 0; bad_len = 0; both_cnt = 0;
    done_cnt = 0; pulse_end_cyc = 0; err_cyc = -1; ignore_inc = 0;
    stall_idx = -1; stall_left = 0; unstable = 0; inc_in_stall = 0;
    stall_started = 1'b0;
    inc_prev = increment_address; dec_prev = decrement_address; err_prev = error;
  endtask

  task automatic start_scan(input int first, input int last);
    first_address = AW'(first);
    last_address  = AW'(last);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_idle(input string tag, input int budget);
    bit finished = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    check({tag, " finishes"}, 32'(finished), 32'd1);
  endtask

  task automatic check_words(input string tag, input int first, input int last);
    int n = ((last - first) % NA + NA) % NA + 1;
    check({tag, " word count"}, 32'(got_addr.size()), 32'(n));
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      int a = (first + i) % NA;
      check($sformatf("%s addr[%0d]", tag, i), 32'(got_addr[i]), 32'(a));
      check($sformatf("%s data[%0d]", tag, i), 32'(got_data[i]), 32'(mem[a]));
    end
  endtask

  task automatic wait_inc(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (increment_address) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, " step pulse seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < NA; i++) mem[i] = DW'($urandom);
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_address = '0; last_address = '0; rom_address = '0; rom_data = mem[0];
    clear_log();
    repeat (3) tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset outputs", {increment_address, decrement_address, out_valid, done, error},
          32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_address", 32'(out_address), 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic scan 0..3 from address 0
    clear_log();
    rom_address = 9'd0;
    start_scan(0, 3);
    check("basic busy after start", 32'(busy), 32'd1);
    run_to_idle("basic", 2000);
    check_words("basic", 0, 3);
    check("basic inc pulses", 32'(inc_pulses), 32'd3);
    check("basic dec pulses", 32'(dec_pulses), 32'd0);
    check("basic pulse widths", 32'(bad_len), 32'd0);
    check("basic done pulses", 32'(done_cnt), 32'd1);
    check("basic error", 32'(error), 32'd0);

    // Seek down from 5 to a single word at 2
    clear_log();
    rom_address = 9'd5;
    start_scan(2, 2);
    run_to_idle("seekdn", 2000);
    check_words("seekdn", 2, 2);
    check("seekdn dec pulses", 32'(dec_pulses), 32'd3);
    check("seekdn inc pulses", 32'(inc_pulses), 32'd0);
    check("seekdn pulse widths", 32'(bad_len), 32'd0);
    check("seekdn done pulses", 32'(done_cnt), 32'd1);

    // Wrapping range 510..1
    clear_log();
    rom_address = 9'd510;
    start_scan(510, 1);
    run_to_idle("wrap", 2000);
    check_words("wrap", 510, 1);
    check("wrap done pulses", 32'(done_cnt), 32'd1);

    // Randomized short scans with a nearby starting address
    for (int r = 0; r < 4; r++) begin
      int f = $urandom_range(0, NA - 1);
      int l = (f + $urandom_range(0, 4)) % NA;
      int s = f + $urandom_range(0, 6) - 3;
      if (s < 0) s = 0;
      if (s > NA - 1) s = NA - 1;
      clear_log();
      rom_address = AW'(s);
      start_scan(f, l);
      run_to_idle($sformatf("rand%0d", r), 4000);
      check_words($sformatf("rand%0d", r), f, l);
      check($sformatf("rand%0d both dirs", r), 32'(both_cnt), 32'd0);
      check($sformatf("rand%0d pulse widths", r), 32'(bad_len), 32'd0);
      check($sformatf("rand%0d done pulses", r), 32'(done_cnt), 32'd1);
    end

    // Backpressure on the second word
    clear_log();
    rom_address = 9'd10;
    stall_idx = 1;
    start_scan(10, 12);
    run_to_idle("stall", 2000);
    check("stall happened", 32'(stall_started), 32'd1);
    check("stall output stable", 32'(unstable), 32'd0);
    check("stall no step pulse", 32'(inc_in_stall), 32'd0);
    check_words("stall", 10, 12);

    // Timeout: reader ignores the second increment
    clear_log();
    rom_address = 9'd0;
    ignore_inc = 2;
    start_scan(0, 5);
    run_to_idle("timeout", 2000);
    check("timeout error", 32'(error), 32'd1);
    check("timeout busy", 32'(busy), 32'd0);
    check("timeout latency", 32'(err_cyc - pulse_end_cyc), 32'(TO));
    check("timeout words", 32'(got_addr.size()), 32'd2);
    check("timeout no done", 32'(done_cnt), 32'd0);
    clear_log();
    start_scan(int'(rom_address), int'(rom_address));
    check("restart clears error", 32'(error), 32'd0);
    run_to_idle("restart", 2000);
    check("restart done", 32'(done_cnt), 32'd1);
    check("restart words", 32'(got_addr.size()), 32'd1);

    // Abort beats start in IDLE
    abort = 1'b1;
    start_scan(0, 0);
    abort = 1'b0;
    check("abort beats start", 32'(busy), 32'd0);

    // Abort during a step pulse
    clear_log();
    rom_address = 9'd20;
    start_scan(20, 25);
    wait_inc("abort");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort inc", 32'(increment_address), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort valid", 32'(out_valid), 32'd0);
    repeat (5) tick();
    check("abort no done", 32'(done_cnt), 32'd0);
    check("abort error kept", 32'(error), 32'd0);
    check("abort stays idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-pulse
    clear_log();
    rom_address = 9'd40;
    start_scan(40, 44);
    wait_inc("reset");
    #2 reset_n = 1'b0;
    #1;
    check("async reset pulses", {increment_address, decrement_address}, 32'd0);
    check("async reset flags", {busy, out_valid, done, error}, 32'd0);
    check("async reset out_data", 32'(out_data), 32'd0);
    check("async reset out_address", 32'(out_address), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_scan_controller.md
# rom_scan_controller

Sequencer that drives `rom_reader` through a contiguous address range without manual button presses. It steps the reader's address with increment/decrement pulses, verifies the reported address, waits a settle time, and captures each data word. Each word is handed downstream over a valid/ready handshake, e.g. to a UART dump path. It sits between `rom_reader` (address/data side) and the host-transfer logic.

## Interface
- `DATA_WIDTH`, 8, width of ROM data word
- `ADDRESS_WIDTH`, 9, width of ROM address
- `PULSE_CYCLES`, 4, clocks `increment_address`/`decrement_address` are held high per step (≥1)
- `SETTLE_CYCLES`, 16, clocks waited after address confirmation before sampling data (≥1)
- `ADDR_TIMEOUT`, 64, clocks allowed for `rom_address` to reach the expected value after a pulse ends

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: begin scan; sampled only in IDLE, DONE or ERROR
- `abort` in 1: cancel scan
- `first_address` in ADDRESS_WIDTH: first address dumped, sampled on accepted `start`
- `last_address` in ADDRESS_WIDTH: last address dumped, sampled on accepted `start`
- `rom_address` in ADDRESS_WIDTH: current address from `rom_reader` `address_line`
- `rom_data` in DATA_WIDTH: data from `rom_reader` `data_line`
- `increment_address` out 1: step pulse to `rom_reader`
- `decrement_address` out 1: step pulse to `rom_reader`
- `out_data` out DATA_WIDTH: captured word
- `out_address` out ADDRESS_WIDTH: address of `out_data`
- `out_valid` out 1: word available
- `out_ready` in 1: downstream accepts word
- `busy` out 1: scan in progress
- `done` out 1: one-cycle pulse after final word transferred
- `error` out 1: sticky address-verification failure

## Operation
- States: IDLE, SEEK_PULSE, SEEK_WAIT, SETTLE, PRESENT, STEP_PULSE, STEP_WAIT, DONE, ERROR.
- Reset: state IDLE; all outputs 0; internal counters 0.
- IDLE/DONE/ERROR + `start` (and not `abort`): latch `first_address`/`last_address`, clear `error`, go to SEEK_WAIT.
- SEEK_WAIT: if `rom_address == first` go to SETTLE. Otherwise set the target to `rom_address ± 1`: increment if `rom_address < first`, decrement if greater. Go to SEEK_PULSE.
- SEEK_PULSE / STEP_PULSE: assert the selected direction output for exactly PULSE_CYCLES clocks. Never assert both directions at once. Then enter the corresponding WAIT state with the timeout counter cleared.
- SEEK_WAIT (after a pulse) / STEP_WAIT: wait for `rom_address == target`. If the timeout counter reaches ADDR_TIMEOUT first, go to ERROR.
- STEP_WAIT success goes to SETTLE.
- SETTLE: count SETTLE_CYCLES, then register `rom_data` into `out_data` and the current address into `out_address`. Go to PRESENT.
- PRESENT: `out_valid`=1, with `out_data`/`out_address` stable until a transfer (`out_valid & out_ready`).
- After a transfer:
  - if `out_address == last`, go to DONE;
  - otherwise target = `out_address + 1` mod 2^ADDRESS_WIDTH, go to STEP_PULSE (increment).
- Range wraps: if `last < first`, the scan runs through all-ones back to 0. Word count = ((last − first) mod 2^ADDRESS_WIDTH) + 1. `first == last` gives exactly one word.
- DONE: `done`=1 for one cycle on entry; `busy`=0; remain in DONE until `start`.
- ERROR: `error`=1 (sticky), `busy`=0, pulses low; left only by `start` or reset.
- `abort`: from any state, go to IDLE next clock. Drop `out_valid`, pulses and `busy`; no `done`; `error` is unchanged. `abort` beats a simultaneous `start`.

## Timing
- `busy`=1 in every state except IDLE, DONE, ERROR; it rises the cycle after an accepted `start`.
- All outputs are registered; no combinational path from inputs to outputs.
- Per word, with no stall, a zero-latency address response and `out_ready` high: PULSE_CYCLES + 1 (address check) + SETTLE_CYCLES + 1 (present).
- First word when already at `first`: 1 + SETTLE_CYCLES + 1 cycles after `start` acceptance to `out_valid`.
- `out_ready` may be high before `out_valid`; the transfer completes in the first cycle `out_valid` is high.
- The timeout counter is wide enough to hold ADDR_TIMEOUT and saturates.
- Reset asserted mid-pulse deasserts `increment_address`/`decrement_address` immediately (asynchronous).

## Test plan
- Basic scan: model reader at address 0, `first`=0, `last`=3, `out_ready`=1 → 4 words at addresses 0..3 with model data; 3 increment pulses of 4 cycles each; `done` pulses once; `busy` falls.
- Seek down: model at 5, `first`=2, `last`=2 → 3 decrement pulses, no increments, then one word at address 2; `done`.
- Wrap: `first`=510, `last`=1 → words at 510, 511, 0, 1; exactly 4 transfers.
- Backpressure: `out_ready` low for 20 cycles while word 1 is presented → `out_valid`, `out_data` and `out_address` are stable the whole time; no increment pulse until the transfer.
- Timeout: model ignores the 2nd increment → `error`=1 exactly ADDR_TIMEOUT cycles after that pulse ends; `busy`=0; a following `start` clears `error`.
- Abort/reset: `abort` during STEP_PULSE → next cycle `increment_address`=0, `busy`=0, no `done`. `reset_n` low mid-scan → all outputs 0 asynchronously.
